// File: rtl/dm_access_pkg.sv
// Shared encodings and op helpers for the data-memory access controller.
package dm_access_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  function automatic logic is_load(op_e op);
    return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
  endfunction

  function automatic logic is_store(op_e op);
    return op inside {OP_SW, OP_SH, OP_SB};
  endfunction

  function automatic size_e op_size(op_e op);
    case (op)
      OP_LW, OP_SW:          return SZ_W;
      OP_LH, OP_LHU, OP_SH:  return SZ_H;
      default:               return SZ_B;
    endcase
  endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Request/response handshake between the CPU MEM stage (master) and the access controller (slave).
interface dm_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_pc, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_pc, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_lane_align.sv
// Combinational byte/half lane handling: load extract with sign/zero extension, and
// store merge of sub-word data into the word read back from memory.
module dm_lane_align
  import dm_access_pkg::*;
(
  input  op_e         op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  assign byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
  assign sext     = (op_i == OP_LB) || (op_i == OP_LH);

  always_comb begin
    load_o  = word_i;
    merge_o = wdata_i;
    case (op_size(op_i))
      SZ_B: begin
        load_o  = {{24{sext & byte_sel[7]}}, byte_sel};
        merge_o = word_i;
        merge_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_H: begin
        load_o  = {{16{sext & half_sel[15]}}, half_sel};
        merge_o = word_i;
        if (addr_lo_i[1]) merge_o[31:16] = wdata_i[15:0];
        else              merge_o[15:0]  = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory initiator: one load/store at a time, sub-word stores via read-modify-write.
// Optional build macro MEM_TRACE_EN adds a $display trace of every committed write.
//
// state   | meaning
// IDLE    | ready for a request
// RD      | memory word read; load extract or store merge
// WR      | single-cycle memory write
// RESP    | response held until consumer takes it
module dm_access_ctrl
  import dm_access_pkg::*;
#(
  parameter int unsigned DM_WORDS = 4096,
  parameter logic [31:0] PC_BASE  = 32'h3000
) (
  input  logic        clk,
  input  logic        rst_n,
  dm_access_ctrl_if.slave bus,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] ADDR_LIMIT = 33'(DM_WORDS) << 2;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [13:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  op_e         req_op;
  size_e       req_size;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic        req_ready;
  logic        resp_valid;

  assign req_op   = op_e'(bus.req_op);
  assign req_size = op_size(req_op);
  assign req_err  = ((req_size == SZ_W) && (bus.req_addr[1:0] != 2'b00))
                  || ((req_size == SZ_H) && bus.req_addr[0])
                  || ({1'b0, bus.req_addr} >= ADDR_LIMIT);

  dm_lane_align u_lane_align (
    .op_i      (op_q),
    .addr_lo_i (addr_q[1:0]),
    .word_i    (mem_rdata),
    .wdata_i   (wdata_q),
    .load_o    (load_data),
    .merge_o   (merge_data)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          op_d    = req_op;
          addr_d  = bus.req_addr[13:0];
          wdata_d = bus.req_wdata;
          rdata_d = '0;
          err_d   = req_err;
          if (req_err)              state_d = ST_RESP;
          else if (req_op == OP_SW) state_d = ST_WR;
          else                      state_d = ST_RD;
        end
      end
      ST_RD: begin
        mem_addr = addr_q[13:2];
        if (is_load(op_q)) begin
          rdata_d = load_data;
          state_d = ST_RESP;
        end else begin
          word_d  = merge_data;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q[13:2];
        // SW skips RD, so its word comes straight from the latched store data.
        mem_wdata = (op_size(op_q) == SZ_W) ? wdata_q : word_q;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

`ifdef MEM_TRACE_EN
  logic [31:0] pc_q;
  logic [17:0] addr_hi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      addr_hi_q <= '0;
    end else if (state_q == ST_IDLE && bus.req_valid) begin
      pc_q      <= bus.req_pc;
      addr_hi_q <= bus.req_addr[31:14];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && state_q == ST_WR)
      $display("@%h: *%h <= %h", pc_q + PC_BASE, {addr_hi_q, addr_q[13:2], 2'b00}, mem_wdata);
  end
`else
`endif

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed vector table, mid-write reset, randomized run vs reference model.
module tb_dm_access_ctrl;
  import dm_access_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  dm_access_ctrl_if bus ();

  dm_access_ctrl #(.DM_WORDS(4096), .PC_BASE(32'h3000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Environment memory: combinational read, posedge write; preload port for setup.
  logic [31:0] mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_idx;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (pl_en) mem[pl_idx]   <= pl_data;
  end
  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx[11:0]; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issue one request, wait for the response, optionally hold resp_ready low for `hold` cycles.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd, output logic e,
                        output int lat, output int wes);
    bit seen;
    bit busy_ok;
    bit stable;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_pc    = $urandom;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0; wes = 0; seen = 0; busy_ok = 1;
    for (int n = 1; n <= 10 && !seen; n++) begin
      @(negedge clk);
      if (mem_we) wes++;
      if (bus.resp_valid) begin
        seen = 1;
        lat  = n;
      end
      if (bus.req_ready) busy_ok = 0;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no resp_valid expected resp within 10 cycles");
      rd = '0; e = 1'b0; lat = 99;
      return;
    end
    chk("busy_ready_low", {31'b0, busy_ok}, 32'd1);
    rd = bus.resp_rdata;
    e  = bus.resp_err;
    stable = 1;
    repeat (hold) begin
      @(negedge clk);
      if (mem_we) wes++;
      if (!bus.resp_valid || bus.resp_rdata !== rd || bus.resp_err !== e || bus.req_ready)
        stable = 0;
    end
    if (hold > 0) chk("hold_stable", {31'b0, stable}, 32'd1);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("back_to_idle", {30'b0, bus.resp_valid, bus.req_ready}, 32'd1);
  endtask

  // Reference model: byte-array view of the first 16 words.
  logic [31:0] ref_mem [16];

  function automatic int ref_size(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd5) return 4;
    if (op == 3'd1 || op == 3'd2 || op == 3'd6) return 2;
    return 1;
  endfunction

  function automatic bit ref_err(input logic [2:0] op, input logic [31:0] a);
    return ((a % ref_size(op)) != 0) || (a >= 32'd16384);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] w, v;
    int sh;
    w  = ref_mem[a[5:2]];
    sh = int'(a[1:0]) * 8;
    case (op)
      3'd0: v = w;
      3'd1, 3'd2: begin
        v = (w >> sh) & 32'hFFFF;
        if (op == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
      end
      default: begin
        v = (w >> sh) & 32'hFF;
        if (op == 3'd3 && v >= 32'h80) v = v - 32'h100;
      end
    endcase
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    int base;
    base = int'(a[1:0]);
    for (int k = 0; k < ref_size(op); k++)
      ref_mem[a[5:2]][8*(base+k) +: 8] = wd[8*k +: 8];
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  vec_t        vecs [15];
  logic [31:0] rd;
  logic        e;
  int          lat, wes;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{OP_LB,  32'h0000_000D, 32'h0,         0, 32'hFFFF_FFAA, 1'b0,  2, 0};
    vecs[1]  = '{OP_LHU, 32'h0000_000E, 32'h0,         0, 32'h0000_8899, 1'b0,  2, 0};
    vecs[2]  = '{OP_LH,  32'h0000_000E, 32'h0,         0, 32'hFFFF_8899, 1'b0,  2, 0};
    vecs[3]  = '{OP_LBU, 32'h0000_000C, 32'h0,         0, 32'h0000_00BB, 1'b0,  2, 0};
    vecs[4]  = '{OP_LW,  32'h0000_000C, 32'h0,         5, 32'h8899_AABB, 1'b0,  2, 0};
    vecs[5]  = '{OP_SB,  32'h0000_000D, 32'h0000_0011, 0, 32'h0,         1'b0,  3, 1};
    vecs[6]  = '{OP_LW,  32'h0000_000C, 32'h0,         0, 32'h8899_11BB, 1'b0,  2, 0};
    vecs[7]  = '{OP_SW,  32'h0000_0006, 32'hFFFF_FFFF, 0, 32'h0,         1'b1, -1, 0};
    vecs[8]  = '{OP_LW,  32'h0000_4000, 32'h0,         0, 32'h0,         1'b1, -1, 0};
    vecs[9]  = '{OP_LH,  32'h0000_000F, 32'h0,         0, 32'h0,         1'b1, -1, 0};
    vecs[10] = '{OP_SH,  32'h0000_0002, 32'hABCD_1234, 2, 32'h0,         1'b0,  3, 1};
    vecs[11] = '{OP_LW,  32'h0000_0000, 32'h0,         0, 32'h1234_0000, 1'b0,  2, 0};
    vecs[12] = '{OP_SW,  32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,         1'b0,  2, 1};
    vecs[13] = '{OP_LB,  32'h0000_0013, 32'h0,         0, 32'hFFFF_FFDE, 1'b0,  2, 0};
    vecs[14] = '{OP_LBU, 32'h0000_0010, 32'h0,         0, 32'h0000_00EF, 1'b0,  2, 0};

    rst_n = 1'b0;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_pc = '0; bus.resp_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_mem_we",     {31'b0, mem_we},         32'd0);
    chk("rst_mem_addr",   {20'b0, mem_addr},       32'd0);
    chk("rst_mem_wdata",  mem_wdata,               32'd0);
    chk("rst_resp_rdata", bus.resp_rdata,          32'd0);
    chk("rst_resp_err",   {31'b0, bus.resp_err},   32'd0);

    preload(0, 32'h0000_0000);
    preload(1, 32'h5A5A_5A5A);
    preload(3, 32'h8899_AABB);
    preload(4, 32'h0000_0000);
    preload(8, 32'h0F0F_0F0F);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].hold, rd, e, lat, wes);
      chk($sformatf("tbl%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("tbl%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
      chk($sformatf("tbl%0d_we_cycles", i), wes, vecs[i].exp_we);
      if (vecs[i].exp_lat >= 0)
        chk($sformatf("tbl%0d_latency", i), lat, vecs[i].exp_lat);
    end
    chk("misaligned_sw_untouched", mem[1], 32'h5A5A_5A5A);
    chk("sb_word3", mem[3], 32'h8899_11BB);

    // Reset during the WR cycle must suppress the write.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_SW; bus.req_addr = 32'h20; bus.req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("wr_we_high", {31'b0, mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr_we_drop",   {31'b0, mem_we},         32'd0);
    chk("rst_wr_ready",     {31'b0, bus.req_ready},  32'd1);
    chk("rst_wr_resp",      {31'b0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wr_word_kept", mem[8], 32'h0F0F_0F0F);
    chk("rst_wr_ready_after", {31'b0, bus.req_ready}, 32'd1);
    do_req(OP_LW, 32'h20, 32'h0, 0, rd, e, lat, wes);
    chk("rst_wr_readback", rd, 32'h0F0F_0F0F);

    // Randomized run against the reference model.
    for (int w = 0; w < 16; w++) begin
      ref_mem[w] = $urandom;
      preload(w, ref_mem[w]);
    end
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  op;
      logic [31:0] a, wd, exp_rd;
      bit          exp_e;
      int          hold;
      op   = 3'($urandom_range(0, 7));
      wd   = $urandom;
      hold = $urandom_range(0, 3);
      case ($urandom_range(0, 15))
        0:       a = 32'h4000 + $urandom_range(0, 255);
        1:       a = $urandom | 32'h8000_0000;
        default: a = $urandom_range(0, 63);
      endcase
      exp_e  = ref_err(op, a);
      exp_rd = (exp_e || op >= 3'd5) ? 32'h0 : ref_load(op, a);
      do_req(op, a, wd, hold, rd, e, lat, wes);
      chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
      chk($sformatf("rnd%0d_err", i), {31'b0, e}, {31'b0, exp_e});
      chk($sformatf("rnd%0d_we_cycles", i), wes, (!exp_e && op >= 3'd5) ? 1 : 0);
      if (!exp_e)
        chk($sformatf("rnd%0d_latency", i), lat, (op >= 3'd6) ? 3 : 2);
      if (!exp_e && op >= 3'd5) ref_store(op, a, wd);
    end
    for (int w = 0; w < 16; w++)
      chk($sformatf("final_word%0d", w), mem[w], ref_mem[w]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
